// File: rtl/m2v_seq_ctrl.sv
// Sequencer for the systolic matrix-vector array: latches a job, enables the array for RUN_CYCLES, then captures and hands off the result.
// Optional job counter enabled with `define M2V_SEQ_CTRL_JOBCNT_EN.
module m2v_seq_ctrl #(
  parameter int DIMENSION  = 4,
  parameter int WIDTH      = 8,
  parameter int RUN_CYCLES = 10
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [DIMENSION*DIMENSION*WIDTH-1:0] m_in,
  input  logic [DIMENSION*WIDTH-1:0]           v_in,
  output logic                                 busy,
  output logic [DIMENSION*DIMENSION*WIDTH-1:0] arr_m,
  output logic [DIMENSION*WIDTH-1:0]           arr_v,
  output logic                                 arr_en,
  input  logic [DIMENSION*WIDTH-1:0]           arr_mv,
  output logic [DIMENSION*WIDTH-1:0]           res,
  output logic                                 res_valid,
  input  logic                                 res_ready
`ifdef M2V_SEQ_CTRL_JOBCNT_EN
  ,
  input  logic                                 job_count_clr,
  output logic [15:0]                          job_count
`endif
);

  localparam logic [7:0] LAST = 8'(RUN_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, HOLD} state_t;

  state_t     state;
  state_t     next;
  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE:    if (start) next = LOAD;
      LOAD:    next = RUN;
      RUN:     if (cnt == LAST) next = HOLD;
      HOLD:    if (res_ready) next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    arr_en    = (state == RUN);
    res_valid = (state == HOLD);
  end

  // Operands are frozen at acceptance; the result is sampled on the last
  // enabled cycle because the array clears its outputs once enable drops.
  always_ff @(posedge clk) begin
    if (!rst) begin
      arr_m <= '0;
      arr_v <= '0;
      res   <= '0;
      cnt   <= '0;
    end else begin
      if (state == IDLE && start) begin
        arr_m <= m_in;
        arr_v <= v_in;
      end
      if (state == RUN) begin
        cnt <= cnt + 8'd1;
        if (cnt == LAST) res <= arr_mv;
      end else if (state != HOLD) begin
        cnt <= '0;
      end
    end
  end

`ifdef M2V_SEQ_CTRL_JOBCNT_EN
  always_ff @(posedge clk) begin
    if (!rst)                        job_count <= '0;
    else if (job_count_clr)          job_count <= '0;
    else if (res_valid && res_ready) job_count <= job_count + 16'd1;
  end
`endif

endmodule

// File: doc/m2v_seq_ctrl.md
Name: m2v_seq_ctrl

Overview:
- Sequencer for the 4-row systolic matrix-vector array. Accepts one matrix/vector job through a start handshake and registers the operands. Holds the operands stable on the array inputs and drives the array enable for a fixed run window.
- Snapshots the array's row results before enable drops, because the array zeroes its outputs when enable is low. Presents the result to a downstream consumer with a valid/ready handshake.

Parameters:
- DIMENSION, 4, matrix order and vector length (array has DIMENSION rows).
- WIDTH, 8, bits per element.
- RUN_CYCLES, 10, enable-high cycles per job; results are sampled on the last one. Legal range 1..255.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-low.
- start  input  1  job request; accepted only in IDLE.
- m_in  input  DIMENSION*DIMENSION*WIDTH  matrix; row r occupies bits [(r+1)*DIMENSION*WIDTH-1 : r*DIMENSION*WIDTH].
- v_in  input  DIMENSION*WIDTH  vector, element i at [(i+1)*WIDTH-1 : i*WIDTH].
- busy  output  1  high in every state except IDLE.
- arr_m  output  DIMENSION*DIMENSION*WIDTH  registered matrix to the array row inputs.
- arr_v  output  DIMENSION*WIDTH  registered vector to the array.
- arr_en  output  1  array enable.
- arr_mv  input  DIMENSION*WIDTH  array row results, row r at [(r+1)*WIDTH-1 : r*WIDTH].
- res  output  DIMENSION*WIDTH  captured result.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts the result.

Behaviour:
- Reset (rst=0 at a clk edge) sets: state IDLE, busy=0, arr_en=0, res_valid=0, and arr_m, arr_v, res and the run counter all to 0.
- Reset applied mid-job aborts the job with no result produced. The array sees arr_en=0 on the next cycle.
- FSM states: IDLE, LOAD, RUN, HOLD.
- IDLE:
  - When start=1, register m_in into arr_m and v_in into arr_v, then go to LOAD.
  - start=0 stays in IDLE.
- LOAD: one cycle with arr_en=0, so the operands are settled before enable rises. Unconditionally goes to RUN with the counter at 0.
- RUN:
  - arr_en=1 on every cycle in this state. The counter increments each cycle.
  - On the cycle where counter==RUN_CYCLES-1, register arr_mv into res, set res_valid=1 and go to HOLD.
  - arr_en is therefore high for exactly RUN_CYCLES consecutive cycles.
- HOLD:
  - arr_en=0; res and res_valid stay stable.
  - When res_valid & res_ready, clear res_valid and go to IDLE. res keeps its value until the next capture.
- start outside IDLE is ignored and not queued. start and res_ready in the same cycle while in HOLD does not start a new job; start is sampled again once back in IDLE.
- arr_m and arr_v change only when a job is accepted in IDLE.
- Latency: start accepted at edge 0, so LOAD is cycle 1, RUN is cycles 2..RUN_CYCLES+1, and res_valid first goes high at cycle RUN_CYCLES+2.
- Minimum job-to-job interval: RUN_CYCLES+3 cycles when res_ready is held at 1.
- Counter width: 8 bits; it is cleared in IDLE and LOAD.
- No arithmetic is performed on the data path; all data is pass-through.

Optional Feature:
- Macro: M2V_SEQ_CTRL_JOBCNT_EN.
- When defined:
  - Adds output job_count [15:0], reset to 0.
  - job_count increments on each completed result handshake (res_valid & res_ready) and wraps from 16'hFFFF to 0.
  - Adds input job_count_clr, synchronous clear; clear wins over a same-cycle increment.
- When undefined, the port and its logic are absent and there is no other behavioural difference.

Test Plan:
1. Reset: hold rst=0 for 3 cycles with start=1 → busy=0, arr_en=0, res_valid=0, res=0, arr_m=0. No job starts while rst=0.
2. Single job, RUN_CYCLES=10, res_ready=1. Stub array drives arr_mv=32'h04030201 only on the 10th enable cycle and 0 otherwise → arr_en high for exactly cycles 2..11; res=32'h04030201; res_valid high 1 cycle at cycle 12; busy low at cycle 13.
3. Backpressure: res_ready=0 for 20 cycles after res_valid → res and res_valid stay stable, arr_en=0, start pulses ignored. res_ready=1 → return to IDLE next cycle.
4. Operand hold: change m_in and v_in on every cycle during RUN → arr_m and arr_v keep the values sampled at the start edge.
5. Reset mid-RUN: rst=0 at the 5th enable cycle → arr_en=0 next cycle, no res_valid. A following start runs a full 10-cycle window.
6. With M2V_SEQ_CTRL_JOBCNT_EN defined: 3 back-to-back jobs → job_count=3; job_count_clr asserted in the same cycle as the 4th handshake → job_count=0.
